// File: rtl/obi_multiport_mem.sv
// obi_multiport_mem: NUM_PORTS independent OBI slave ports sharing one word array.
// Each port has a programmable grant wait, fixed response latency and outstanding limit.
// Out-of-range accesses are granted normally and answered with err=1, rdata=0.
// Optional random grant back-pressure per port: define OBI_MEM_RAND_STALL_EN.
module obi_multiport_mem #(
  parameter int unsigned NUM_PORTS       = 2,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned DEPTH_WORDS     = 8192,
  parameter logic [31:0] BASE_ADDR       = 32'h0,
  parameter int unsigned GNT_WAIT        = 0,
  parameter int unsigned RVALID_LAT      = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [15:0] STALL_SEED      = 16'hACE1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NUM_PORTS-1:0]                req_i,
  input  logic [NUM_PORTS-1:0]                we_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]   be_i,
  input  logic [NUM_PORTS*32-1:0]             addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]     wdata_i,
  output logic [NUM_PORTS-1:0]                gnt_o,
  output logic [NUM_PORTS-1:0]                rvalid_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]     rdata_o,
  output logic [NUM_PORTS-1:0]                err_o
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned OFS_W = (BE_W > 1) ? $clog2(BE_W) : 0;
  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [IDX_W-1:0]      idx [NUM_PORTS];
  logic [NUM_PORTS-1:0]  in_range;
  logic [NUM_PORTS-1:0]  wait_ok;
  logic [NUM_PORTS-1:0]  stall;
  logic [OUT_W-1:0]      outst [NUM_PORTS];

  // Response pipeline, stage 0 loaded at the grant edge, last stage drives the outputs.
  logic [NUM_PORTS-1:0]  pipe_vld [RVALID_LAT];
  logic [NUM_PORTS-1:0]  pipe_err [RVALID_LAT];
  logic [DATA_WIDTH-1:0] pipe_dat [RVALID_LAT][NUM_PORTS];

  // Address decode: the extra MSB of the subtraction is the below-base borrow.
  always_comb begin
    logic [32:0] off;
    logic [31:0] woff;
    off      = '0;
    woff     = '0;
    in_range = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      off         = {1'b0, addr_i[p*32 +: 32]} - {1'b0, BASE_ADDR};
      woff        = off[31:0] >> OFS_W;
      in_range[p] = !off[32] && (woff < DEPTH_WORDS);
      idx[p]      = woff[IDX_W-1:0];
    end
  end

  // Grant wait qualification.
  if (GNT_WAIT == 0) begin : g_nowait
    assign wait_ok = '1;
  end else begin : g_wait
    localparam int unsigned WAIT_W = $clog2(GNT_WAIT + 1);
    logic [WAIT_W-1:0] wait_cnt [NUM_PORTS];

    // Count consecutive ungranted request cycles, saturating at GNT_WAIT.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) wait_cnt[p] <= '0;
      end else begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
          if (!req_i[p] || gnt_o[p]) begin
            wait_cnt[p] <= '0;
          end else if (wait_cnt[p] != WAIT_W'(GNT_WAIT)) begin
            wait_cnt[p] <= wait_cnt[p] + WAIT_W'(1);
          end
        end
      end
    end

    // Request has waited long enough.
    always_comb begin
      wait_ok = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        wait_ok[p] = (wait_cnt[p] >= WAIT_W'(GNT_WAIT));
      end
    end
  end

`ifdef OBI_MEM_RAND_STALL_EN
  logic [15:0] lfsr [NUM_PORTS];

  // Per-port Galois LFSR x^16+x^14+x^13+x^11, free running.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) lfsr[p] <= STALL_SEED ^ 16'(p);
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        lfsr[p] <= {1'b0, lfsr[p][15:1]} ^ (lfsr[p][0] ? 16'hB400 : 16'h0000);
      end
    end
  end

  // LFSR LSB blocks the grant for that cycle.
  always_comb begin
    stall = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) stall[p] = lfsr[p][0];
  end
`else
  logic unused_seed;
  assign unused_seed = ^STALL_SEED;
  assign stall       = '0;
`endif

  // Grant is combinational on the request and held low during reset.
  always_comb begin
    gnt_o = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      gnt_o[p] = rst_ni && req_i[p] && wait_ok[p] && !stall[p] &&
                 (outst[p] < OUT_W'(MAX_OUTSTANDING));
    end
  end

  // Array writes; iterating from the highest port lets lower ports win per byte.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (gnt_o[NUM_PORTS-1-i] && we_i[NUM_PORTS-1-i] && in_range[NUM_PORTS-1-i]) begin
        for (int unsigned b = 0; b < BE_W; b++) begin
          if (be_i[(NUM_PORTS-1-i)*BE_W + b]) begin
            mem[idx[NUM_PORTS-1-i]][b*8 +: 8] <= wdata_i[(NUM_PORTS-1-i)*DATA_WIDTH + b*8 +: 8];
          end
        end
      end
    end
  end

  // Response pipeline; reads sample the array before same-edge writes land.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned s = 0; s < RVALID_LAT; s++) begin
        pipe_vld[s] <= '0;
        pipe_err[s] <= '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) pipe_dat[s][p] <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        pipe_vld[0][p] <= gnt_o[p];
        pipe_err[0][p] <= gnt_o[p] && !in_range[p];
        pipe_dat[0][p] <= (gnt_o[p] && !we_i[p] && in_range[p]) ? mem[idx[p]] : '0;
      end
      for (int unsigned s = 1; s < RVALID_LAT; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
        pipe_err[s] <= pipe_err[s-1];
        for (int unsigned p = 0; p < NUM_PORTS; p++) pipe_dat[s][p] <= pipe_dat[s-1][p];
      end
    end
  end

  // Outstanding count: +1 on grant, -1 on response, unchanged when both.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) outst[p] <= '0;
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        case ({gnt_o[p], rvalid_o[p]})
          2'b10:   outst[p] <= outst[p] + OUT_W'(1);
          2'b01:   outst[p] <= outst[p] - OUT_W'(1);
          default: outst[p] <= outst[p];
        endcase
      end
    end
  end

  assign rvalid_o = pipe_vld[RVALID_LAT-1];
  assign err_o    = pipe_err[RVALID_LAT-1];

  // Flatten last-stage read data onto the port bus.
  always_comb begin
    rdata_o = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = pipe_dat[RVALID_LAT-1][p];
    end
  end

endmodule
